// File: rtl/leaf_router_rr.sv
// Leaf router: per-input FIFOs, GPU->spine routing, round-robin spine->GPU arbitration.
// Define LEAF_ROUTER_DROP_CNT_EN to build the saturating misroute counter; otherwise drop_count is 0.

module leaf_router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // A pop frees the slot, so a push into a full FIFO is legal in the same cycle.
  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
endmodule

module leaf_router_rr #(
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter int         N_SPINES   = 4,
  parameter logic [3:0] GROUP_ID   = 4'b0100
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arb_enable,
  input  logic [DWIDTH-1:0]          gpu_in_data,
  input  logic                       gpu_in_valid,
  input  logic [5:0]                 gpu_dest_addr,
  output logic                       gpu_in_ready,
  output logic [DWIDTH-1:0]          gpu_out_data,
  output logic                       gpu_out_valid,
  input  logic                       gpu_out_ready,
  input  logic [N_SPINES*DWIDTH-1:0] spine_in_data,
  input  logic [N_SPINES-1:0]        spine_in_valid,
  input  logic [N_SPINES*6-1:0]      spine_dest_addr,
  output logic [N_SPINES-1:0]        spine_in_ready,
  output logic [N_SPINES*DWIDTH-1:0] spine_out_data,
  output logic [N_SPINES-1:0]        spine_out_valid,
  input  logic [N_SPINES-1:0]        spine_out_ready,
  output logic [N_SPINES:0]          fifo_full,
  output logic [N_SPINES:0]          fifo_empty,
  output logic [2:0]                 current_grant,
  output logic [15:0]                drop_count
);
  localparam int SW = (N_SPINES > 1) ? $clog2(N_SPINES) : 1;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  logic [DWIDTH+5:0] gpu_head;
  logic              gpu_full, gpu_empty, gpu_pop;
  logic [SW-1:0]     gpu_tgt;

  logic [DWIDTH-1:0]   sp_head_data [N_SPINES];
  logic [3:0]          sp_head_grp  [N_SPINES];
  logic [N_SPINES-1:0] sp_full, sp_empty, sp_pop, sp_req, sp_misroute;

  logic [N_SPINES-1:0] sp_out_vld_q, sp_load;
  logic [DWIDTH-1:0]   sp_out_data_q [N_SPINES];
  logic                gpu_out_vld_q, gpu_load;
  logic [DWIDTH-1:0]   gpu_out_data_q;

  arb_state_e    state_q, state_d;
  logic [SW-1:0] grant_q, grant_d, ptr_q, ptr_d, pick, cand;
  logic          pick_vld;
  logic          unused_spine_addr;

  leaf_router_fifo #(.WIDTH(DWIDTH+6), .DEPTH(FIFO_DEPTH)) u_gpu_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (gpu_in_valid && !gpu_full),
    .push_dat_i ({gpu_dest_addr, gpu_in_data}),
    .pop_i      (gpu_pop),
    .head_dat_o (gpu_head),
    .full_o     (gpu_full),
    .empty_o    (gpu_empty)
  );

  // Spine FIFOs keep only the group field; the spine-select bits are meaningless on ingress.
  for (genvar i = 0; i < N_SPINES; i++) begin : g_spine
    logic [DWIDTH+3:0] head;
    leaf_router_fifo #(.WIDTH(DWIDTH+4), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (spine_in_valid[i] && !sp_full[i]),
      .push_dat_i ({spine_dest_addr[i*6+2 +: 4], spine_in_data[i*DWIDTH +: DWIDTH]}),
      .pop_i      (sp_pop[i]),
      .head_dat_o (head),
      .full_o     (sp_full[i]),
      .empty_o    (sp_empty[i])
    );
    assign sp_head_data[i] = head[DWIDTH-1:0];
    assign sp_head_grp[i]  = head[DWIDTH+3:DWIDTH];
    assign sp_req[i]       = !sp_empty[i] && (sp_head_grp[i] == GROUP_ID);
    assign sp_misroute[i]  = !sp_empty[i] && (sp_head_grp[i] != GROUP_ID);
    assign spine_out_data[i*DWIDTH +: DWIDTH] = sp_out_data_q[i];
  end

  assign unused_spine_addr = ^spine_dest_addr;

  assign gpu_in_ready    = !gpu_full;
  assign spine_in_ready  = ~sp_full;
  assign fifo_full       = {sp_full, gpu_full};
  assign fifo_empty      = {sp_empty, gpu_empty};
  assign spine_out_valid = sp_out_vld_q;
  assign gpu_out_valid   = gpu_out_vld_q;
  assign gpu_out_data    = gpu_out_data_q;
  assign current_grant   = (state_q == ARB_GRANT) ? 3'(grant_q) : 3'b111;

  assign gpu_tgt = SW'(gpu_head[DWIDTH+1:DWIDTH] & 2'(N_SPINES-1));

  // Loopback flits are discarded; others wait for their spine register to be free or draining.
  always_comb begin
    gpu_pop = 1'b0;
    sp_load = '0;
    if (!gpu_empty) begin
      if (gpu_head[DWIDTH+5:DWIDTH+2] == GROUP_ID) begin
        gpu_pop = 1'b1;
      end else if (!sp_out_vld_q[gpu_tgt] || spine_out_ready[gpu_tgt]) begin
        gpu_pop          = 1'b1;
        sp_load[gpu_tgt] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_out_vld_q <= '0;
      for (int i = 0; i < N_SPINES; i++) sp_out_data_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_SPINES; i++) begin
        if (sp_load[i]) begin
          sp_out_vld_q[i]  <= 1'b1;
          sp_out_data_q[i] <= gpu_head[DWIDTH-1:0];
        end else if (spine_out_ready[i]) begin
          sp_out_vld_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 0; k < N_SPINES; k++) begin
      cand = SW'((int'(ptr_q) + k) % N_SPINES);
      if (!pick_vld && sp_req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Misrouted heads drain every cycle regardless of the arbiter.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    gpu_load = 1'b0;
    sp_pop   = sp_misroute;
    case (state_q)
      ARB_IDLE: begin
        if (arb_enable && pick_vld) begin
          state_d = ARB_GRANT;
          grant_d = pick;
        end
      end
      ARB_GRANT: begin
        if (!gpu_out_vld_q || gpu_out_ready) begin
          gpu_load        = 1'b1;
          sp_pop[grant_q] = 1'b1;
          state_d         = ARB_IDLE;
          ptr_d           = SW'((int'(grant_q) + 1) % N_SPINES);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpu_out_vld_q  <= 1'b0;
      gpu_out_data_q <= '0;
    end else if (gpu_load) begin
      gpu_out_vld_q  <= 1'b1;
      gpu_out_data_q <= sp_head_data[grant_q];
    end else if (gpu_out_ready) begin
      gpu_out_vld_q <= 1'b0;
    end
  end

`ifdef LEAF_ROUTER_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_q};
    for (int i = 0; i < N_SPINES; i++) drop_sum = drop_sum + 17'(sp_misroute[i]);
    drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif
endmodule

// File: tb/tb_leaf_router_rr.sv
// Directed bench for leaf_router_rr at default parameters.
module tb_leaf_router_rr;
`ifdef LEAF_ROUTER_DROP_CNT_EN
  localparam int EXP_DROP = 3;
`else
  localparam int EXP_DROP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        arb_enable;
  logic [15:0] gpu_in_data;
  logic        gpu_in_valid;
  logic [5:0]  gpu_dest_addr;
  logic        gpu_in_ready;
  logic [15:0] gpu_out_data;
  logic        gpu_out_valid;
  logic        gpu_out_ready;
  logic [63:0] spine_in_data;
  logic [3:0]  spine_in_valid;
  logic [23:0] spine_dest_addr;
  logic [3:0]  spine_in_ready;
  logic [63:0] spine_out_data;
  logic [3:0]  spine_out_valid;
  logic [3:0]  spine_out_ready;
  logic [4:0]  fifo_full;
  logic [4:0]  fifo_empty;
  logic [2:0]  current_grant;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;

  leaf_router_rr dut (
    .clk(clk), .reset(reset), .arb_enable(arb_enable),
    .gpu_in_data(gpu_in_data), .gpu_in_valid(gpu_in_valid), .gpu_dest_addr(gpu_dest_addr),
    .gpu_in_ready(gpu_in_ready), .gpu_out_data(gpu_out_data), .gpu_out_valid(gpu_out_valid),
    .gpu_out_ready(gpu_out_ready), .spine_in_data(spine_in_data), .spine_in_valid(spine_in_valid),
    .spine_dest_addr(spine_dest_addr), .spine_in_ready(spine_in_ready),
    .spine_out_data(spine_out_data), .spine_out_valid(spine_out_valid),
    .spine_out_ready(spine_out_ready), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .current_grant(current_grant), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_spine(input int idx, input logic [15:0] d, input logic [5:0] a);
    spine_in_data[idx*16 +: 16] = d;
    spine_dest_addr[idx*6 +: 6] = a;
  endtask

  task automatic do_reset;
    reset           = 1'b1;
    arb_enable      = 1'b1;
    gpu_in_data     = '0;
    gpu_in_valid    = 1'b0;
    gpu_dest_addr   = '0;
    gpu_out_ready   = 1'b1;
    spine_in_data   = '0;
    spine_in_valid  = '0;
    spine_dest_addr = '0;
    spine_out_ready = '1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    total++; if ({gpu_out_valid, spine_out_valid} !== 5'b0) begin bad++;
      $display("FAIL rst_out_valid: got %b want 00000", {gpu_out_valid, spine_out_valid}); end
    total++; if ({gpu_out_data, spine_out_data} !== 80'h0) begin bad++;
      $display("FAIL rst_out_data: got %h want 0", {gpu_out_data, spine_out_data}); end
    total++; if ({gpu_in_ready, spine_in_ready} !== 5'b11111) begin bad++;
      $display("FAIL rst_in_ready: got %b want 11111", {gpu_in_ready, spine_in_ready}); end
    total++; if (fifo_empty !== 5'b11111 || fifo_full !== 5'b00000) begin bad++;
      $display("FAIL rst_flags: got empty=%b full=%b want 11111/00000", fifo_empty, fifo_full); end
    total++; if (current_grant !== 3'b111) begin bad++;
      $display("FAIL rst_grant: got %b want 111", current_grant); end
    total++; if (drop_count !== 16'h0) begin bad++;
      $display("FAIL rst_drop: got %h want 0000", drop_count); end
  endtask

  task automatic test_gpu_to_spine;
    do_reset;
    gpu_in_data   = 16'hA5A5;
    gpu_dest_addr = 6'b001110;
    gpu_in_valid  = 1'b1;
    tick;
    gpu_in_valid = 1'b0;
    total++; if (spine_out_valid !== 4'b0000) begin bad++;
      $display("FAIL g2s_early: got %b want 0000", spine_out_valid); end
    tick;
    total++; if (spine_out_valid !== 4'b0100) begin bad++;
      $display("FAIL g2s_valid: got %b want 0100", spine_out_valid); end
    total++; if (spine_out_data[47:32] !== 16'hA5A5) begin bad++;
      $display("FAIL g2s_data: got %h want a5a5", spine_out_data[47:32]); end
    tick;
    total++; if (spine_out_valid !== 4'b0000) begin bad++;
      $display("FAIL g2s_drain: got %b want 0000", spine_out_valid); end
  endtask

  task automatic test_gpu_stream;
    logic [5:0]  da [4] = '{6'b000000, 6'b010001, 6'b000101, 6'b111111};
    logic [15:0] dd [4] = '{16'hB000, 16'hB001, 16'hB002, 16'hB003};
    logic [17:0] exp_q [3] = '{{2'd0, 16'hB000}, {2'd1, 16'hB002}, {2'd3, 16'hB003}};
    logic [17:0] got_q [$];
    do_reset;
    for (int c = 0; c < 8; c++) begin
      gpu_in_valid = (c < 4);
      if (c < 4) begin
        gpu_in_data   = dd[c];
        gpu_dest_addr = da[c];
      end
      tick;
      for (int s = 0; s < 4; s++)
        if (spine_out_valid[s]) got_q.push_back({2'(s), spine_out_data[s*16 +: 16]});
    end
    gpu_in_valid = 1'b0;
    total++; if (got_q.size() != 3) begin bad++;
      $display("FAIL stream_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL stream_item%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_spine_rr;
    logic [2:0]  gq [$];
    logic [15:0] dq [$];
    int first = -1;
    do_reset;
    for (int i = 0; i < 4; i++) set_spine(i, 16'h1000 + 16'(i), 6'b010000);
    spine_in_valid = 4'hF;
    tick;
    spine_in_valid = 4'h0;
    for (int c = 2; c <= 14; c++) begin
      tick;
      if (current_grant != 3'b111) gq.push_back(current_grant);
      if (gpu_out_valid) begin
        dq.push_back(gpu_out_data);
        if (first < 0) first = c;
      end
    end
    total++; if (first != 3) begin bad++;
      $display("FAIL rr_latency: got %0d want 3", first); end
    total++; if (gq.size() != 4 || dq.size() != 4) begin bad++;
      $display("FAIL rr_count: got grants=%0d flits=%0d want 4/4", gq.size(), dq.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (i >= gq.size() || gq[i] !== 3'(i)) begin bad++;
        $display("FAIL rr_grant%0d: got %b want %b", i, gq[i], 3'(i)); end
      total++; if (i >= dq.size() || dq[i] !== 16'h1000 + 16'(i)) begin bad++;
        $display("FAIL rr_data%0d: got %h want %h", i, dq[i], 16'h1000 + 16'(i)); end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] rx [$];
    int k = 0;
    logic acc;
    do_reset;
    gpu_out_ready = 1'b0;
    set_spine(1, 16'h2000, 6'b010000);
    for (int c = 0; c < 20; c++) begin
      spine_in_valid[1] = (k < 10);
      spine_in_data[31:16] = 16'h2000 + 16'(k);
      acc = spine_in_ready[1] && (k < 10);
      tick;
      if (acc) k++;
    end
    total++; if (k != 9) begin bad++;
      $display("FAIL bp_accepted: got %0d want 9", k); end
    total++; if (spine_in_ready[1] !== 1'b0 || fifo_full[2] !== 1'b1) begin bad++;
      $display("FAIL bp_full: got ready=%b full=%b want 0/1", spine_in_ready[1], fifo_full[2]); end
    total++; if (gpu_out_valid !== 1'b1 || gpu_out_data !== 16'h2000) begin bad++;
      $display("FAIL bp_hold: got v=%b d=%h want 1/2000", gpu_out_valid, gpu_out_data); end
    gpu_out_ready = 1'b1;
    for (int c = 0; c < 60 && rx.size() < 10; c++) begin
      spine_in_valid[1] = (k < 10);
      spine_in_data[31:16] = 16'h2000 + 16'(k);
      acc = spine_in_ready[1] && (k < 10);
      if (gpu_out_valid) rx.push_back(gpu_out_data);
      tick;
      if (acc) k++;
    end
    spine_in_valid = '0;
    total++; if (rx.size() != 10) begin bad++;
      $display("FAIL bp_rx_count: got %0d want 10", rx.size()); end
    for (int j = 0; j < 10; j++) begin
      total++; if (j >= rx.size() || rx[j] !== 16'h2000 + 16'(j)) begin bad++;
        $display("FAIL bp_rx%0d: got %h want %h", j, rx[j], 16'h2000 + 16'(j)); end
    end
  endtask

  task automatic test_misroute;
    logic saw = 1'b0;
    do_reset;
    for (int c = 0; c < 9; c++) begin
      spine_in_valid[0] = (c < 3);
      set_spine(0, 16'hC000 + 16'(c), 6'b001100);
      tick;
      saw = saw | gpu_out_valid;
    end
    spine_in_valid = '0;
    total++; if (saw !== 1'b0) begin bad++;
      $display("FAIL mis_gpu_out: got %b want 0", saw); end
    total++; if (drop_count !== 16'(EXP_DROP)) begin bad++;
      $display("FAIL mis_drop: got %0d want %0d", drop_count, EXP_DROP); end
    total++; if (fifo_empty !== 5'b11111) begin bad++;
      $display("FAIL mis_empty: got %b want 11111", fifo_empty); end
  endtask

  task automatic test_arb_enable;
    do_reset;
    arb_enable = 1'b0;
    set_spine(2, 16'hD002, 6'b010000);
    spine_in_valid[2] = 1'b1;
    tick;
    spine_in_valid = '0;
    for (int c = 0; c < 4; c++) tick;
    total++; if (current_grant !== 3'b111 || gpu_out_valid !== 1'b0) begin bad++;
      $display("FAIL arb_frozen: got grant=%b v=%b want 111/0", current_grant, gpu_out_valid); end
    total++; if (fifo_empty[3] !== 1'b0) begin bad++;
      $display("FAIL arb_pending: got empty=%b want 0", fifo_empty[3]); end
    arb_enable = 1'b1;
    tick;
    total++; if (current_grant !== 3'd2 || gpu_out_valid !== 1'b0) begin bad++;
      $display("FAIL arb_grant: got grant=%b v=%b want 010/0", current_grant, gpu_out_valid); end
    tick;
    total++; if (gpu_out_valid !== 1'b1 || gpu_out_data !== 16'hD002) begin bad++;
      $display("FAIL arb_out: got v=%b d=%h want 1/d002", gpu_out_valid, gpu_out_data); end
  endtask

  task automatic test_reset_mid;
    int wait_c = 0;
    do_reset;
    gpu_out_ready = 1'b0;
    set_spine(0, 16'hE000, 6'b010000);
    set_spine(3, 16'hE300, 6'b000011);
    spine_in_valid = 4'b1001;
    tick;
    set_spine(0, 16'hE001, 6'b010000);
    spine_in_valid = 4'b0001;
    tick;
    spine_in_valid = '0;
    while (!gpu_out_valid && wait_c < 10) begin
      tick;
      wait_c++;
    end
    total++; if (gpu_out_valid !== 1'b1) begin bad++;
      $display("FAIL mid_setup: got v=%b want 1 within 10 cycles", gpu_out_valid); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    total++; if (gpu_out_valid !== 1'b0 || spine_out_valid !== 4'b0) begin bad++;
      $display("FAIL mid_valid: got %b/%b want 0/0000", gpu_out_valid, spine_out_valid); end
    total++; if (fifo_empty !== 5'b11111) begin bad++;
      $display("FAIL mid_empty: got %b want 11111", fifo_empty); end
    total++; if (drop_count !== 16'h0 || current_grant !== 3'b111) begin bad++;
      $display("FAIL mid_state: got drop=%h grant=%b want 0000/111", drop_count, current_grant); end
    tick;
    total++; if (gpu_out_valid !== 1'b0) begin bad++;
      $display("FAIL mid_quiet: got %b want 0", gpu_out_valid); end
    gpu_out_ready = 1'b1;
  endtask

  initial begin
    test_reset;
    test_gpu_to_spine;
    test_gpu_stream;
    test_spine_rr;
    test_backpressure;
    test_misroute;
    test_arb_enable;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/leaf_router_rr.md
# leaf_router_rr

Parametrised leaf router joining one GPU port to N_SPINES spine links inside a group. It replaces the unbuffered tie-off style leaf with:
- a per-input FIFO on every port;
- a real valid/ready handshake on every port;
- round-robin arbitration of spine traffic onto the single GPU output;
- destination decode against GROUP_ID.

It sits between the GPU endpoint and the spine layer in each group.

## Interface
- DWIDTH, 16, flit data width.
- FIFO_DEPTH, 8, entries per input FIFO; power of two, ≥2.
- N_SPINES, 4, spine links; one of 1, 2, 4.
- GROUP_ID, 4'b0100, this group's ID, compared with dest_addr[5:2].
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- arb_enable  in  1  1 = arbiter may issue new grants; 0 = freeze new grants.
- gpu_in_data / gpu_in_valid / gpu_dest_addr  in  DWIDTH/1/6  GPU ingress.
- gpu_in_ready  out  1  = !gpu FIFO full.
- gpu_out_data / gpu_out_valid  out  DWIDTH/1  GPU egress.
- gpu_out_ready  in  1  GPU egress backpressure.
- spine_in_data / spine_in_valid / spine_dest_addr  in  N_SPINES*DWIDTH / N_SPINES / N_SPINES*6  spine ingress, packed; spine i is slice i.
- spine_in_ready  out  N_SPINES  per-spine !full.
- spine_out_data / spine_out_valid  out  N_SPINES*DWIDTH / N_SPINES  spine egress.
- spine_out_ready  in  N_SPINES  spine egress backpressure.
- fifo_full, fifo_empty  out  N_SPINES+1  each; bit 0 = GPU, bit i+1 = spine i.
- current_grant  out  3  spine index currently granted to the GPU output; 3'b111 = none.
- drop_count  out  16  misrouted spine flits dropped.

## Operation
- Every input is written to its FIFO on in_valid && in_ready. Flits offered while full are not accepted; the sender holds them.
- GPU FIFO head:
  - If dest_addr[5:2] == GROUP_ID (loopback), pop and discard it.
  - Otherwise route to spine s = dest_addr[1:0] & (N_SPINES-1).
  - Pop only when spine s's output register is empty or draining this cycle.
- Spine FIFO head with dest_addr[5:2] == GROUP_ID requests the GPU output.
- Spine FIFO head with any other group is misrouted:
  - popped and dropped;
  - drop_count increments, saturating at 16'hFFFF.
- GPU-output arbiter FSM, states IDLE and GRANT:
  - IDLE → GRANT when arb_enable and any spine is requesting. Pick the first requester at or after ptr, cyclically.
  - In GRANT: transfer one flit, then return to IDLE. Set ptr = grant+1 mod N_SPINES.
  - arb_enable = 0 freezes IDLE only; a grant already made completes.
- Output registers: each of gpu_out and spine_out[i] is a single-entry register. out_valid holds, with data stable, until out_ready.

## Timing
- Reset clears all FIFOs, output registers and drop_count, sets ptr = 0 and state = IDLE. Outputs after reset:
  - all *_out_valid = 0, all *_out_data = 0;
  - *_in_ready = 1, fifo_empty = all 1, fifo_full = 0;
  - current_grant = 3'b111.
- Latency from ingress acceptance to out_valid:
  - GPU→spine: 2 cycles, with the output idle;
  - spine→GPU: 3 cycles (FIFO, grant, output register), arbiter idle.
- Throughput:
  - GPU→spine: 1 flit/cycle when the targeted spine outputs are ready;
  - spine→GPU: 1 flit per 2 cycles, because of the IDLE/GRANT alternation.
- FIFO full and empty flags are registered. A write and a read on a full FIFO in the same cycle is allowed: the read frees the slot, count is unchanged, ready stays 0 that cycle.
- Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-transfer discards in-flight flits. Nothing is emitted in the cycle after reset.

## Configuration
- LEAF_ROUTER_DROP_CNT_EN defined: the 16-bit saturating drop counter is built.
- Not defined: drop_count is tied to 0. Misrouted flits are still dropped.

## Test plan
- Reset, then GPU sends data 16'hA5A5, dest 6'b0011_10 → spine_out_valid[2] = 1 with 16'hA5A5 exactly 2 cycles later; all other spine_out_valid stay 0.
- Spines 0–3 each hold one flit, dest 6'b0100_00, gpu_out_ready = 1 → GPU receives them in order 0, 1, 2, 3. current_grant sequence is 0, 1, 2, 3.
- gpu_out_ready = 0 and spine 1 streams 10 flits to GPU → after FIFO_DEPTH accepted plus the 1-flit grant/output stage, spine_in_ready[1] = 0 and fifo_full[2] = 1. Release: all flits arrive in order, none lost.
- Spine 0 sends 3 flits with dest group 4'b0011 → nothing appears on gpu_out. drop_count = 3 when the macro is defined, 0 when not.
- arb_enable = 0 with spine 2 requesting → current_grant = 3'b111 and no gpu_out_valid. arb_enable = 1 → the flit appears 2 cycles later.
- Reset pulsed while gpu_out_valid = 1 → next cycle gpu_out_valid = 0, fifo_empty = all 1, drop_count = 0.
